// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and latency counter width.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } muldiv_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } muldiv_state_e;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_ZERO = 5'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 5'd1;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit. The result is computed at issue and
// held in pending registers; HI/LO commit after the configured latency.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cancel,
    input  logic              rd_hi,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [CNT_W-1:0]  MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0]  DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [DATA_W-1:0] ZERO_W  = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_W   = {{(DATA_W-1){1'b0}}, 1'b1};

    muldiv_state_e       state_r, state_n;
    logic [CNT_W-1:0]    cnt_r, cnt_n;
    logic [DATA_W-1:0]   hi_r, hi_n, lo_r, lo_n;
    logic [DATA_W-1:0]   pend_hi_r, pend_hi_n, pend_lo_r, pend_lo_n;
    logic                pend_wr_r, pend_wr_n;
    logic                busy_r;

    logic [2*DATA_W-1:0] acc_s, prod_u_s, prod_s_s;
    logic [DATA_W-1:0]   a_mag_s, b_mag_s, sdiv_b_s, udiv_b_s;
    logic [DATA_W-1:0]   squo_mag_s, srem_mag_s, squo_s, srem_s, uquo_s, urem_s;
    logic                b_zero_s;

    assign acc_s    = {hi_r, lo_r};
    assign prod_u_s = {ZERO_W, a} * {ZERO_W, b};
    // Sign-extended operands give the signed product modulo 2^(2*DATA_W).
    assign prod_s_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};

    // Signed divide on magnitudes avoids the MIN/-1 overflow case: the
    // magnitude of MIN wraps to itself, which is the correct unsigned value.
    assign b_zero_s   = (b == ZERO_W);
    assign a_mag_s    = a[DATA_W-1] ? -a : a;
    assign b_mag_s    = b[DATA_W-1] ? -b : b;
    assign sdiv_b_s   = b_zero_s ? ONE_W : b_mag_s;
    assign udiv_b_s   = b_zero_s ? ONE_W : b;
    assign squo_mag_s = a_mag_s / sdiv_b_s;
    assign srem_mag_s = a_mag_s % sdiv_b_s;
    assign squo_s     = (a[DATA_W-1] ^ b[DATA_W-1]) ? -squo_mag_s : squo_mag_s;
    assign srem_s     = a[DATA_W-1] ? -srem_mag_s : srem_mag_s;
    assign uquo_s     = a / udiv_b_s;
    assign urem_s     = a % udiv_b_s;

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        hi_n      = hi_r;
        lo_n      = lo_r;
        pend_hi_n = pend_hi_r;
        pend_lo_n = pend_lo_r;
        pend_wr_n = pend_wr_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT:  begin {pend_hi_n, pend_lo_n} = prod_s_s;         pend_wr_n = 1'b1; cnt_n = MUL_CNT; state_n = ST_RUN; end
                        OP_MULTU: begin {pend_hi_n, pend_lo_n} = prod_u_s;         pend_wr_n = 1'b1; cnt_n = MUL_CNT; state_n = ST_RUN; end
                        OP_MADD:  begin {pend_hi_n, pend_lo_n} = acc_s + prod_s_s; pend_wr_n = 1'b1; cnt_n = MUL_CNT; state_n = ST_RUN; end
                        OP_MADDU: begin {pend_hi_n, pend_lo_n} = acc_s + prod_u_s; pend_wr_n = 1'b1; cnt_n = MUL_CNT; state_n = ST_RUN; end
                        OP_MSUB:  begin {pend_hi_n, pend_lo_n} = acc_s - prod_s_s; pend_wr_n = 1'b1; cnt_n = MUL_CNT; state_n = ST_RUN; end
                        OP_MSUBU: begin {pend_hi_n, pend_lo_n} = acc_s - prod_u_s; pend_wr_n = 1'b1; cnt_n = MUL_CNT; state_n = ST_RUN; end
                        OP_DIV:   begin pend_hi_n = srem_s; pend_lo_n = squo_s; pend_wr_n = !b_zero_s; cnt_n = DIV_CNT; state_n = ST_RUN; end
                        OP_DIVU:  begin pend_hi_n = urem_s; pend_lo_n = uquo_s; pend_wr_n = !b_zero_s; cnt_n = DIV_CNT; state_n = ST_RUN; end
                        OP_MTHI:  hi_n = a;
                        OP_MTLO:  lo_n = a;
                        default:  state_n = ST_IDLE;
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cancel || (cnt_r == CNT_ONE)) begin
                    if (!cancel && pend_wr_r) begin
                        hi_n = pend_hi_r;
                        lo_n = pend_lo_r;
                    end else begin
                        hi_n = hi_r;
                    end
                    state_n   = ST_IDLE;
                    cnt_n     = CNT_ZERO;
                    pend_hi_n = ZERO_W;
                    pend_lo_n = ZERO_W;
                    pend_wr_n = 1'b0;
                end else begin
                    cnt_n = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, pending and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
            pend_hi_r <= ZERO_W;
            pend_lo_r <= ZERO_W;
            pend_wr_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            hi_r      <= hi_n;
            lo_r      <= lo_n;
            pend_hi_r <= pend_hi_n;
            pend_lo_r <= pend_lo_n;
            pend_wr_r <= pend_wr_n;
            busy_r    <= (state_n == ST_RUN);
        end
    end

    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign rdata = rd_hi ? hi_r : lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic         clk = 1'b0;
    logic         reset, start, cancel, rd_hi;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] rdata, hi, lo;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_hi, m_lo;

    muldiv_unit #(.DATA_W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .rd_hi(rd_hi), .rdata(rdata), .busy(busy),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MUL_LAT;
            OP_DIV, OP_DIVU: return DIV_LAT;
            default: return 0;
        endcase
    endfunction

    // Reference: what HI/LO hold once the op has fully completed.
    task automatic model_apply(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] acc, up, sp;
        longint sx, sy;
        acc = {m_hi, m_lo};
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        up  = {32'd0, x} * {32'd0, y};
        sp  = 64'(sx * sy);
        case (o)
            OP_MULT:  {m_hi, m_lo} = sp;
            OP_MULTU: {m_hi, m_lo} = up;
            OP_MADD:  {m_hi, m_lo} = acc + sp;
            OP_MADDU: {m_hi, m_lo} = acc + up;
            OP_MSUB:  {m_hi, m_lo} = acc - sp;
            OP_MSUBU: {m_hi, m_lo} = acc - up;
            OP_DIV:   if (y != 32'd0) begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
            OP_DIVU:  if (y != 32'd0) begin m_lo = x / y; m_hi = x % y; end
            OP_MTHI:  m_hi = x;
            OP_MTLO:  m_lo = x;
            default:  ;
        endcase
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts busy cycles starting from the current one, bounded.
    task automatic run_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        rd_hi = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    endtask

    task automatic test_mult();
        int n;
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        run_busy(n);
        checks++; if (n != 5) begin errors++; $display("FAIL mult_busy got %0d want 5", n); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_result got %h/%h want ffffffff/fffffffa", hi, lo); end
        model_apply(OP_MULT, 32'hFFFFFFFE, 32'd3);
    endtask

    task automatic test_div();
        int n;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        run_busy(n);
        checks++; if (n != 10) begin errors++; $display("FAIL div_busy got %0d want 10", n); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_result got %h/%h want ffffffff/fffffffd", hi, lo); end
        issue(OP_DIVU, 32'd7, 32'd0);
        run_busy(n);
        checks++; if (n != 10) begin errors++; $display("FAIL divu0_busy got %0d want 10", n); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL divu0_keep got %h/%h want ffffffff/fffffffd", hi, lo); end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_busy(n);
        checks++; if (hi !== 32'd0 || lo !== 32'h80000000) begin errors++; $display("FAIL div_min got %h/%h want 0/80000000", hi, lo); end
        m_hi = 32'd0; m_lo = 32'h80000000;
    endtask

    task automatic test_madd();
        int n;
        issue(OP_MTHI, 32'd5, 32'd0);
        checks++; if (busy !== 1'b0 || hi !== 32'd5) begin errors++; $display("FAIL mthi got busy=%0b hi=%h want 0/5", busy, hi); end
        issue(OP_MTLO, 32'd7, 32'd0);
        checks++; if (busy !== 1'b0 || lo !== 32'd7) begin errors++; $display("FAIL mtlo got busy=%0b lo=%h want 0/7", busy, lo); end
        issue(OP_MADD, 32'd2, 32'd3);
        rd_hi = 1'b0; #1;
        checks++; if (rdata !== 32'd7) begin errors++; $display("FAIL rdata_pre got %h want 7", rdata); end
        run_busy(n);
        checks++; if (hi !== 32'd5 || lo !== 32'd13) begin errors++; $display("FAIL madd got %h/%h want 5/d", hi, lo); end
        issue(OP_MSUBU, 32'd1, 32'd14);
        run_busy(n);
        checks++; if (hi !== 32'd4 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL msubu got %h/%h want 4/ffffffff", hi, lo); end
        m_hi = 32'd4; m_lo = 32'hFFFFFFFF;
    endtask

    task automatic test_cancel();
        issue(OP_DIV, 32'd100, 32'd3);
        tick(); tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %0b want 0", busy); end
        repeat (12) tick();
        checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL cancel_keep got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
        op = OP_MTHI; a = 32'h1234; start = 1'b1; cancel = 1'b1;
        tick();
        op = OP_MULT; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0; cancel = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL cancel_start got busy=%0b %h/%h want 0 %h/%h", busy, hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MULTU, 32'd6, 32'd7);
        model_apply(OP_MULTU, 32'd6, 32'd7);
        tick();
        op = OP_MULT; a = 32'd1000; b = 32'd1000; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0b want 0", busy); end
        checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL b2b_result got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
        run_busy(n);
        checks++; if (n != 0 || hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL b2b_noqueue got busy_cycles=%0d %h/%h want 0 %h/%h", n, hi, lo, m_hi, m_lo); end
        issue(4'hF, 32'd1, 32'd2);
        checks++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL undef_op got busy=%0b %h/%h want 0 %h/%h", busy, hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_mid();
        int n;
        issue(OP_MULT, 32'd11, 32'd13);
        tick();
        reset = 1'b1; cancel = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; cancel = 1'b0; start = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid got busy=%0b %h/%h want 0 0/0", busy, hi, lo); end
        issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        model_apply(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_busy(n);
        checks++; if (n != MUL_LAT || hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rstmid_fresh got n=%0d %h/%h want %0d %h/%h", n, hi, lo, MUL_LAT, m_hi, m_lo); end
    endtask

    task automatic test_random();
        int n, lat;
        logic [3:0] o;
        logic [W-1:0] x, y, pre_hi, pre_lo;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 12));
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 9));
                2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                default: ;
            endcase
            pre_hi = m_hi; pre_lo = m_lo;
            lat = exp_lat(o);
            issue(o, x, y);
            model_apply(o, x, y);
            if (lat > 0) begin
                rd_hi = 1'($urandom_range(0, 1)); #1;
                checks++; if (rdata !== (rd_hi ? pre_hi : pre_lo)) begin errors++; $display("FAIL rnd_rdata_run op=%0d got %h want %h", o, rdata, rd_hi ? pre_hi : pre_lo); end
            end
            run_busy(n);
            checks++; if (n != lat) begin errors++; $display("FAIL rnd_lat op=%0d got %0d want %0d", o, n, lat); end
            checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rnd_result op=%0d a=%h b=%h got %h/%h want %h/%h", o, x, y, hi, lo, m_hi, m_lo); end
            rd_hi = 1'b1; #1;
            checks++; if (rdata !== m_hi) begin errors++; $display("FAIL rnd_rdata_hi got %h want %h", rdata, m_hi); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; rd_hi = 1'b0;
        op = OP_NOP; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_madd();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
